// File: rtl/ni_receive_control_pkg.sv
// Shared definitions for the NI receive path: FSM state encoding and
// reset polarity.
package ni_receive_control_pkg;

  // Level of rst that holds the block in reset.
  localparam logic RST_ASSERTED = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_HOLD = 2'd2
  } rx_state_t;

endpackage

// File: rtl/ni_rx_flit_buffer.sv
// Slot register file holding one packet, MAXFLITS x FLITWD.
// Single write port addressed by slot index, full parallel read.
module ni_rx_flit_buffer
  import ni_receive_control_pkg::*;
#(
  parameter int FLITWD   = 32,
  parameter int MAXFLITS = 8,
  parameter int CNTWD    = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [CNTWD-1:0]             wr_idx,
  input  logic [FLITWD-1:0]            wr_data,
  output logic [MAXFLITS*FLITWD-1:0]   rd_data
);

  logic [MAXFLITS-1:0][FLITWD-1:0] slot_q;

  // Write the addressed slot; all other slots keep their contents.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ASSERTED) begin
      slot_q <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < MAXFLITS; k++) begin
        if (wr_idx == CNTWD'(k)) begin
          slot_q[k] <= wr_data;
        end
      end
    end
  end

  assign rd_data = slot_q;

endmodule

// File: rtl/ni_receive_control.sv
// Receive-side flit sequencer: decodes the header length, collects body
// flits into the slot buffer and holds the packet until the consumer
// takes it, stalling the switch meanwhile.
//
// state   | meaning
// --------+-------------------------------------------
// ST_IDLE | waiting for a header flit
// ST_RECV | collecting body flits
// ST_HOLD | packet complete, waiting for packet_taken
module ni_receive_control
  import ni_receive_control_pkg::*;
#(
  parameter int FLITWD   = 32,
  parameter int MAXFLITS = 8,
  parameter int CNTWD    = 3,
  parameter int LEN_LSB  = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [FLITWD-1:0]            flit_in,
  input  logic                         valid_in,
  output logic                         stall_out,
  output logic [MAXFLITS*FLITWD-1:0]   packet_data,
  output logic [CNTWD:0]               packet_num_flits,
  output logic                         packet_valid,
  input  logic                         packet_taken,
  output logic [CNTWD-1:0]             flit_counter,
  output logic                         protocol_error
);

  rx_state_t          state_q, state_d;
  logic [CNTWD-1:0]   cnt_q, cnt_d;
  logic [CNTWD:0]     num_q, num_d;
  logic               err_q, err_d;
  logic               wr_en;
  logic [CNTWD-1:0]   wr_idx;
  logic [CNTWD:0]     len;
  logic               len_ok;
  logic               accept;

  assign len    = flit_in[LEN_LSB +: CNTWD+1];
  assign len_ok = (len != '0) && (len <= (CNTWD+1)'(MAXFLITS));
  assign accept = valid_in && !stall_out;

  // State, counter, length and error pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ASSERTED) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      err_q   <= err_d;
    end
  end

  // Next-state, slot write control and header length check.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (len_ok) begin
            wr_en  = 1'b1;
            wr_idx = '0;
            num_d  = len;
            if (len == (CNTWD+1)'(1)) begin
              state_d = ST_HOLD;
            end else begin
              state_d = ST_RECV;
              cnt_d   = CNTWD'(1);
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RECV: begin
        if (accept) begin
          wr_en = 1'b1;
          if ({1'b0, cnt_q} == num_q - (CNTWD+1)'(1)) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNTWD'(1);
          end
        end
      end
      ST_HOLD: begin
        if (packet_taken) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  ni_rx_flit_buffer #(
    .FLITWD   (FLITWD),
    .MAXFLITS (MAXFLITS),
    .CNTWD    (CNTWD)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (flit_in),
    .rd_data (packet_data)
  );

  assign stall_out        = (state_q == ST_HOLD);
  assign packet_valid     = (state_q == ST_HOLD);
  assign packet_num_flits = num_q;
  assign flit_counter     = cnt_q;
  assign protocol_error   = err_q;

endmodule

// File: tb/tb_ni_receive_control.sv
// Directed bench for ni_receive_control: inputs driven and outputs
// sampled on the falling edge, expected values hand-computed.
module tb_ni_receive_control;

  localparam int FLITWD   = 32;
  localparam int MAXFLITS = 8;
  localparam int CNTWD    = 3;

  logic                        clk;
  logic                        rst;
  logic [FLITWD-1:0]           flit_in;
  logic                        valid_in;
  logic                        stall_out;
  logic [MAXFLITS*FLITWD-1:0]  packet_data;
  logic [CNTWD:0]              packet_num_flits;
  logic                        packet_valid;
  logic                        packet_taken;
  logic [CNTWD-1:0]            flit_counter;
  logic                        protocol_error;

  int pass_cnt  = 0;
  int total_cnt = 0;

  ni_receive_control #(
    .FLITWD(FLITWD), .MAXFLITS(MAXFLITS), .CNTWD(CNTWD), .LEN_LSB(0)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .flit_in          (flit_in),
    .valid_in         (valid_in),
    .stall_out        (stall_out),
    .packet_data      (packet_data),
    .packet_num_flits (packet_num_flits),
    .packet_valid     (packet_valid),
    .packet_taken     (packet_taken),
    .flit_counter     (flit_counter),
    .protocol_error   (protocol_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [FLITWD-1:0] slot(input int k);
    return packet_data[k*FLITWD +: FLITWD];
  endfunction

  // Present one flit for exactly one rising edge.
  task automatic send_flit(input logic [FLITWD-1:0] d);
    valid_in = 1'b1;
    flit_in  = d;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic take;
    packet_taken = 1'b1;
    @(negedge clk);
    packet_taken = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; valid_in = 1'b1; flit_in = 32'hFFFF_0003; packet_taken = 1'b0;
    idle(2);
    total_cnt++;
    if ({packet_valid, stall_out, protocol_error, flit_counter, packet_num_flits} !== '0 || packet_data !== '0)
      $display("FAIL reset_outputs: got pv=%b st=%b err=%b cnt=%0d num=%0d data_nz=%b, want all 0",
               packet_valid, stall_out, protocol_error, flit_counter, packet_num_flits, |packet_data);
    else pass_cnt++;
    rst = 1'b1; valid_in = 1'b0;
    idle(3);
    total_cnt++;
    if ({packet_valid, stall_out, protocol_error, flit_counter, packet_num_flits} !== '0 || packet_data !== '0)
      $display("FAIL reset_idle: got pv=%b st=%b cnt=%0d num=%0d, want all 0",
               packet_valid, stall_out, flit_counter, packet_num_flits);
    else pass_cnt++;
  endtask

  task automatic test_single_flit;
    send_flit(32'hA5A5_0001);
    total_cnt++;
    if (packet_valid !== 1'b1 || stall_out !== 1'b1 || packet_num_flits !== 4'd1 || flit_counter !== 3'd0)
      $display("FAIL single_hold: got pv=%b st=%b num=%0d cnt=%0d, want 1 1 1 0",
               packet_valid, stall_out, packet_num_flits, flit_counter);
    else pass_cnt++;
    total_cnt++;
    if (slot(0) !== 32'hA5A5_0001)
      $display("FAIL single_slot0: got %h want a5a50001", slot(0));
    else pass_cnt++;
    take();
    total_cnt++;
    if (packet_valid !== 1'b0 || stall_out !== 1'b0)
      $display("FAIL single_take: got pv=%b st=%b want 0 0", packet_valid, stall_out);
    else pass_cnt++;
  endtask

  task automatic test_gaps;
    logic [FLITWD-1:0] f [4];
    logic [CNTWD-1:0] exp_cnt [4];
    f[0] = 32'h1111_0004; f[1] = 32'h2222_0000; f[2] = 32'h3333_0000; f[3] = 32'h4444_0000;
    exp_cnt[0] = 3'd1; exp_cnt[1] = 3'd2; exp_cnt[2] = 3'd3; exp_cnt[3] = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) idle(2);
      send_flit(f[i]);
      total_cnt++;
      if (flit_counter !== exp_cnt[i] || packet_valid !== (i == 3))
        $display("FAIL gaps_step%0d: got cnt=%0d pv=%b want cnt=%0d pv=%b",
                 i, flit_counter, packet_valid, exp_cnt[i], (i == 3));
      else pass_cnt++;
    end
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (slot(i) !== f[i]) $display("FAIL gaps_slot%0d: got %h want %h", i, slot(i), f[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (packet_num_flits !== 4'd4) $display("FAIL gaps_num: got %0d want 4", packet_num_flits);
    else pass_cnt++;
    take();
  endtask

  task automatic test_backpressure;
    send_flit(32'h3333_0001);
    valid_in = 1'b1; flit_in = 32'h4444_0002;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total_cnt++;
      if (stall_out !== 1'b1 || slot(0) !== 32'h3333_0001 || flit_counter !== 3'd0)
        $display("FAIL bp_hold%0d: got st=%b slot0=%h cnt=%0d want 1 33330001 0",
                 i, stall_out, slot(0), flit_counter);
      else pass_cnt++;
    end
    packet_taken = 1'b1;
    @(negedge clk);
    packet_taken = 1'b0;
    total_cnt++;
    if (stall_out !== 1'b0 || slot(0) !== 32'h3333_0001)
      $display("FAIL bp_take: got st=%b slot0=%h want 0 33330001", stall_out, slot(0));
    else pass_cnt++;
    @(negedge clk);
    valid_in = 1'b0;
    total_cnt++;
    if (flit_counter !== 3'd1 || slot(0) !== 32'h4444_0002 || packet_num_flits !== 4'd2)
      $display("FAIL bp_accept: got cnt=%0d slot0=%h num=%0d want 1 44440002 2",
               flit_counter, slot(0), packet_num_flits);
    else pass_cnt++;
    send_flit(32'h5555_0000);
    total_cnt++;
    if (packet_valid !== 1'b1 || slot(1) !== 32'h5555_0000)
      $display("FAIL bp_complete: got pv=%b slot1=%h want 1 55550000", packet_valid, slot(1));
    else pass_cnt++;
    take();
  endtask

  task automatic test_illegal;
    logic [FLITWD-1:0] bad [2];
    bad[0] = 32'h6666_0000; bad[1] = 32'h7777_0009;
    for (int i = 0; i < 2; i++) begin
      send_flit(bad[i]);
      total_cnt++;
      if (protocol_error !== 1'b1 || stall_out !== 1'b0 || flit_counter !== 3'd0 ||
          packet_num_flits !== 4'd2 || slot(0) !== 32'h4444_0002)
        $display("FAIL illegal%0d_pulse: got err=%b st=%b cnt=%0d num=%0d slot0=%h want 1 0 0 2 44440002",
                 i, protocol_error, stall_out, flit_counter, packet_num_flits, slot(0));
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (protocol_error !== 1'b0 || packet_valid !== 1'b0)
        $display("FAIL illegal%0d_once: got err=%b pv=%b want 0 0", i, protocol_error, packet_valid);
      else pass_cnt++;
    end
    send_flit(32'h8888_0002);
    send_flit(32'h9999_0000);
    total_cnt++;
    if (packet_valid !== 1'b1 || packet_num_flits !== 4'd2 ||
        slot(0) !== 32'h8888_0002 || slot(1) !== 32'h9999_0000)
      $display("FAIL illegal_recover: got pv=%b num=%0d s0=%h s1=%h want 1 2 88880002 99990000",
               packet_valid, packet_num_flits, slot(0), slot(1));
    else pass_cnt++;
    take();
  endtask

  task automatic test_reset_mid;
    send_flit(32'hAAAA_0005);
    send_flit(32'hBBBB_0000);
    total_cnt++;
    if (flit_counter !== 3'd2) $display("FAIL mid_before: got cnt=%0d want 2", flit_counter);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({packet_valid, stall_out, protocol_error, flit_counter, packet_num_flits} !== '0 || packet_data !== '0)
      $display("FAIL mid_clear: got pv=%b st=%b cnt=%0d num=%0d data_nz=%b want all 0",
               packet_valid, stall_out, flit_counter, packet_num_flits, |packet_data);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (flit_counter !== 3'd0) $display("FAIL mid_cnt0: got %0d want 0", flit_counter);
    else pass_cnt++;
    send_flit(32'hCCCC_0003);
    send_flit(32'hDDDD_0000);
    send_flit(32'hEEEE_0000);
    total_cnt++;
    if (packet_valid !== 1'b1 || packet_num_flits !== 4'd3 || slot(0) !== 32'hCCCC_0003 ||
        slot(1) !== 32'hDDDD_0000 || slot(2) !== 32'hEEEE_0000)
      $display("FAIL mid_fresh: got pv=%b num=%0d s0=%h s1=%h s2=%h",
               packet_valid, packet_num_flits, slot(0), slot(1), slot(2));
    else pass_cnt++;
    take();
  endtask

  initial begin
    test_reset();
    test_single_flit();
    test_gaps();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
